write_back: RTL and testbench

Final pipeline stage, consuming the registered memory-stage outputs (`pc_me`, `load_me`, `read_data_me`, `alu_mode_me`, `alu_result_me`, `rd_me`, `rd_address_me`).
- Selects the write-back value and drives the `rd_wb`/`rd_address_wb`/`rd_data_wb` bus to the register file and forwarding logic.
- Logs every committed register write into a small commit-trace FIFO with a valid/ready port, for lock-step comparison against the ISA simulator.
- Keeps a retired-write counter and a sticky overflow flag.

---
 rtl/write_back_pkg.sv | 17 +
 rtl/write_back_trace_fifo.sv | 60 ++++++
 rtl/write_back.sv | 92 +++++++++
 tb/tb_write_back.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/write_back_pkg.sv
// rtl/write_back_pkg.sv - shared widths and the commit-trace entry type
package Constants;
  localparam int WIDTH          = 32;
  localparam int REG_ADDR_WIDTH = 5;
endpackage

package Trace;
  import Constants::*;

  localparam int TRACE_DEPTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0]          pc;
    logic [REG_ADDR_WIDTH-1:0] rd_address;
    logic [WIDTH-1:0]          rd_data;
  } trace_entry_t;
endpackage

// File: rtl/write_back_trace_fifo.sv
// rtl/write_back_trace_fifo.sv - synchronous FIFO of commit-trace entries
module trace_fifo
  import Trace::*;
#(
  parameter int DEPTH = Trace::TRACE_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  trace_entry_t push_entry,
  input  logic         pop,
  output trace_entry_t head_entry,
  output logic         full,
  output logic         empty,
  output logic [LW-1:0] level
);

  trace_entry_t      mem [DEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [LW-1:0]     level_q;

  // Callers only push when there is room (or a pop frees one) and only pop when non-empty.
  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign level      = level_q;
  // Zeroed head while empty so consumers never see stale data.
  assign head_entry = empty ? '0 : mem[head_q];

  // Entry storage: written at the tail, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_q] <= push_entry;
    end
  end

  // Pointers wrap naturally; the occupancy counter tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/write_back.sv
// rtl/write_back.sv - write-back stage: register-file bus, commit trace, retire counter
module write_back
  import Constants::*;
  import Trace::*;
#(
  parameter int TRACE_DEPTH = Trace::TRACE_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            pc_me,
  input  logic                        load_me,
  input  logic [WIDTH-1:0]            read_data_me,
  input  logic                        alu_mode_me,
  input  logic [WIDTH-1:0]            alu_result_me,
  input  logic                        rd_me,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_address_me,
  output logic                        rd_wb,
  output logic [REG_ADDR_WIDTH-1:0]   rd_address_wb,
  output logic [WIDTH-1:0]            rd_data_wb,
  output logic                        trace_valid,
  input  logic                        trace_ready,
  output logic [WIDTH-1:0]            trace_pc,
  output logic [REG_ADDR_WIDTH-1:0]   trace_rd_address,
  output logic [WIDTH-1:0]            trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0] trace_level,
  output logic [31:0]                 retired_count,
  output logic                        overflow
);

  logic         commit;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  trace_entry_t push_entry;
  trace_entry_t head_entry;
  logic [31:0]  retired_q;
  logic         overflow_q;
  logic         unused_alu_mode;

  // alu_mode_me is carried for visibility only; selection keys off load_me.
  assign unused_alu_mode = alu_mode_me;

  // Writes to r0 are architecturally invisible, so they are not committed.
  assign commit        = rd_me && (rd_address_me != '0);
  assign rd_wb         = commit;
  assign rd_address_wb = rd_address_me;
  assign rd_data_wb    = load_me ? read_data_me : alu_result_me;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_pop   = trace_valid && trace_ready;
  assign fifo_push  = commit && (!fifo_full || fifo_pop);
  assign push_entry = '{pc: pc_me, rd_address: rd_address_me, rd_data: rd_data_wb};

  trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head_entry (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (trace_level)
  );

  assign trace_valid      = !fifo_empty;
  assign trace_pc         = head_entry.pc;
  assign trace_rd_address = head_entry.rd_address;
  assign trace_rd_data    = head_entry.rd_data;

  // Count every commit, including those the trace had to drop; remember any drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (commit) begin
        retired_q <= retired_q + 32'd1;
      end
      if (commit && !fifo_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign retired_count = retired_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - randomized self-checking bench against a queue model
module tb_write_back;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] pc_me;
  logic        load_me;
  logic [31:0] read_data_me;
  logic        alu_mode_me;
  logic [31:0] alu_result_me;
  logic        rd_me;
  logic [4:0]  rd_address_me;
  logic        rd_wb;
  logic [4:0]  rd_address_wb;
  logic [31:0] rd_data_wb;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd_address;
  logic [31:0] trace_rd_data;
  logic [2:0]  trace_level;
  logic [31:0] retired_count;
  logic        overflow;

  write_back #(.TRACE_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_me            (pc_me),
    .load_me          (load_me),
    .read_data_me     (read_data_me),
    .alu_mode_me      (alu_mode_me),
    .alu_result_me    (alu_result_me),
    .rd_me            (rd_me),
    .rd_address_me    (rd_address_me),
    .rd_wb            (rd_wb),
    .rd_address_wb    (rd_address_wb),
    .rd_data_wb       (rd_data_wb),
    .trace_valid      (trace_valid),
    .trace_ready      (trace_ready),
    .trace_pc         (trace_pc),
    .trace_rd_address (trace_rd_address),
    .trace_rd_data    (trace_rd_data),
    .trace_level      (trace_level),
    .retired_count    (retired_count),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_count;
  logic        m_ovf;
  int          total;
  int          bad;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        e_commit;
    logic [31:0] e_data;
    ent_t        h;
    e_commit = rd_me && (rd_address_me != 0);
    e_data   = load_me ? read_data_me : alu_result_me;
    check_val("rd_wb", rd_wb, e_commit);
    check_val("rd_address_wb", rd_address_wb, rd_address_me);
    check_val("rd_data_wb", rd_data_wb, e_data);
    if (m_q.size() > 0) h = m_q[0];
    else h = '{pc: 0, rd: 0, data: 0};
    check_val("trace_valid", trace_valid, m_q.size() > 0);
    check_val("trace_pc", trace_pc, h.pc);
    check_val("trace_rd_address", trace_rd_address, h.rd);
    check_val("trace_rd_data", trace_rd_data, h.data);
    check_val("trace_level", trace_level, m_q.size());
    check_val("retired_count", retired_count, m_count);
    check_val("overflow", overflow, m_ovf);
  endtask

  task automatic model_edge();
    logic do_pop;
    logic was_full;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      return;
    end
    do_pop   = (m_q.size() > 0) && trace_ready;
    was_full = (m_q.size() == DEPTH);
    if (do_pop) void'(m_q.pop_front());
    if (rd_me && rd_address_me != 0) begin
      m_count = m_count + 32'd1;
      if (!was_full || do_pop) begin
        e.pc   = pc_me;
        e.rd   = rd_address_me;
        e.data = load_me ? read_data_me : alu_result_me;
        m_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // Inputs are set right after a rising edge; outputs checked on the falling edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic ld, input logic [31:0] rdata,
                       input logic [31:0] alu, input logic rdm, input logic [4:0] addr,
                       input logic rdy);
    pc_me = pc; load_me = ld; read_data_me = rdata; alu_result_me = alu;
    alu_mode_me = !ld; rd_me = rdm; rd_address_me = addr; trace_ready = rdy;
  endtask

  task automatic bubble(input logic rdy);
    drive(0, 0, 0, 0, 0, 0, rdy);
  endtask

  logic [31:0] cnt0;
  logic [31:0] first_pc;

  initial begin
    total = 0; bad = 0;
    m_count = 0; m_ovf = 0;
    rst = 1'b1;
    bubble(0);
    #1;
    check_val("reset_valid", trace_valid, 0);
    check_val("reset_level", trace_level, 0);
    check_val("reset_count", retired_count, 0);
    check_val("reset_overflow", overflow, 0);
    step(); step();
    rst = 1'b0;

    // load select and r0 suppression
    drive(32'h100, 1, 32'hDEADBEEF, 32'h10, 1, 5, 0);
    #1;
    check_val("load_data", rd_data_wb, 32'hDEADBEEF);
    check_val("load_wb", rd_wb, 1);
    step();
    cnt0 = m_count;
    drive(32'h104, 1, 32'hDEADBEEF, 32'h10, 1, 0, 0);
    #1;
    check_val("r0_wb", rd_wb, 0);
    step();
    check_val("r0_count", retired_count, cnt0);
    bubble(1);
    step(); step();

    // single ALU commit, then one ready pulse
    drive(32'h40, 0, 32'h5555, 7, 1, 3, 0);
    step();
    bubble(0);
    check_val("single_pc", trace_pc, 32'h40);
    check_val("single_rd", trace_rd_address, 3);
    check_val("single_data", trace_rd_data, 7);
    check_val("single_valid", trace_valid, 1);
    bubble(1);
    step();
    bubble(0);
    check_val("single_drained", trace_valid, 0);
    check_val("single_zero_pc", trace_pc, 0);
    step();

    // fill with no pops: fifth commit dropped
    cnt0 = m_count;
    first_pc = 32'h200;
    for (int i = 0; i < 5; i++) begin
      drive(first_pc + 32'(4 * i), 0, 0, 32'(100 + i), 1, 5'(i + 1), 0);
      step();
    end
    bubble(0);
    check_val("fill_level", trace_level, DEPTH);
    check_val("fill_overflow", overflow, 1);
    check_val("fill_count", retired_count, cnt0 + 5);
    check_val("fill_head", trace_pc, first_pc);

    // full with simultaneous push and pop, sustained
    for (int i = 0; i < 10; i++) begin
      drive(32'h300 + 32'(4 * i), i[0], $urandom, $urandom, 1, 5'(i + 1), 1);
      step();
      check_val("full_pp_level", trace_level, DEPTH);
    end

    // randomized traffic with bursts of back-pressure
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive($urandom, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3) != 0, a,
            ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      step();
    end

    // asynchronous reset mid-cycle with three entries queued
    bubble(1);
    for (int i = 0; i < DEPTH + 1; i++) step();
    for (int i = 0; i < 3; i++) begin
      drive(32'h500 + 32'(4 * i), 0, 0, 32'(i), 1, 5'(i + 7), 0);
      step();
    end
    bubble(0);
    check_val("pre_reset_level", trace_level, 3);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_valid", trace_valid, 0);
    check_val("async_level", trace_level, 0);
    check_val("async_count", retired_count, 0);
    check_val("async_overflow", overflow, 0);
    check_val("async_pc", trace_pc, 0);
    m_q.delete(); m_count = 0; m_ovf = 0;
    step();
    rst = 1'b0;

    // counter wrap
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    m_count = 32'hFFFFFFFF;
    drive(32'h600, 0, 0, 32'h1, 1, 9, 1);
    step();
    bubble(1);
    check_val("wrap_count", retired_count, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
